atm_session_ctrl: RTL

- Sequencing controller for the ATM account datapath: card/PIN table, balance table, PIN-update write-back.
- Accepts one transaction request: card number, PIN, opcode, amount/new PIN.
- Serially searches the account table, verifies the PIN, applies the operation, and reports a status code and the resulting balance.
- Owns the account register arrays; a load port populates them from the host side between sessions.

---
 rtl/atm_session_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: serial card search, PIN check, balance/PIN update, host load port.
// Optional per-entry wrong-PIN lockout is built only when ATM_LOCKOUT_EN is defined.
module atm_session_ctrl #(
  parameter int N         = 4,
  parameter int MAX_TRIES = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       ready,
  input  logic [9:0]                 card_in,
  input  logic [10:0]                pin_in,
  input  logic [1:0]                 op,
  input  logic [10:0]                amount,
  input  logic [10:0]                new_pin,
  input  logic                       load_we,
  input  logic [$clog2(N+1)-1:0]     load_idx,
  input  logic [9:0]                 load_card,
  input  logic [10:0]                load_pin,
  input  logic [10:0]                load_bal,
  output logic                       done,
  output logic [2:0]                 status,
  output logic [10:0]                bal_out
);
  localparam int IW = $clog2(N+1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_NOCARD   = 3'd1;
  localparam logic [2:0] ST_BADPIN   = 3'd2;
  localparam logic [2:0] ST_LOCKED   = 3'd3;
  localparam logic [2:0] ST_INSUFF   = 3'd4;
  localparam logic [2:0] ST_OVERFLOW = 3'd5;
  localparam logic [2:0] ST_SAMEPIN  = 3'd6;

  typedef struct packed {
    logic [9:0]  card;
    logic [10:0] pin;
    logic [1:0]  op;
    logic [10:0] amount;
    logic [10:0] new_pin;
  } req_t;

  logic [1:0]        state;
  logic [IW-1:0]     idx;
  req_t              req;
  logic [N:0][9:0]   tcard;
  logic [N:0][10:0]  tpin;
  logic [N:0][10:0]  tbal;

  logic [10:0] cur_bal, cur_pin, ex_bal;
  logic [11:0] sum;
  logic [2:0]  ex_status;
  logic        hit, locked, bal_we, pin_we;

  assign ready   = (state == S_IDLE);
  assign done    = (state == S_DONE);
  assign cur_bal = tbal[idx];
  assign cur_pin = tpin[idx];
  assign hit     = (tcard[idx] == req.card);
  assign sum     = {1'b0, cur_bal} + {1'b0, req.amount};

`ifdef ATM_LOCKOUT_EN
  localparam int FW = $clog2(MAX_TRIES+1);
  logic [N:0][FW-1:0] tfail;
  assign locked = (tfail[idx] >= FW'(MAX_TRIES));
`else
  assign locked = 1'b0;
`endif

  // EXEC decision: lockout beats PIN check, PIN check beats the operation itself
  always_comb begin
    ex_status = ST_OK;
    ex_bal    = cur_bal;
    bal_we    = 1'b0;
    pin_we    = 1'b0;
    if (locked) begin
      ex_status = ST_LOCKED;
    end else if (req.pin != cur_pin) begin
      ex_status = ST_BADPIN;
    end else begin
      case (req.op)
        2'd1: begin
          if (req.amount > cur_bal) ex_status = ST_INSUFF;
          else begin
            ex_bal = cur_bal - req.amount;
            bal_we = 1'b1;
          end
        end
        2'd2: begin
          if (sum[11]) ex_status = ST_OVERFLOW;
          else begin
            ex_bal = sum[10:0];
            bal_we = 1'b1;
          end
        end
        2'd3: begin
          if (req.new_pin == cur_pin) ex_status = ST_SAMEPIN;
          else pin_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      req     <= '0;
      status  <= '0;
      bal_out <= '0;
      tcard   <= '0;
      tpin    <= '0;
      tbal    <= '0;
`ifdef ATM_LOCKOUT_EN
      tfail   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // load lands on this edge, so a same-cycle request searches the new contents
          if (load_we && load_idx <= IW'(N)) begin
            tcard[load_idx] <= load_card;
            tpin[load_idx]  <= load_pin;
            tbal[load_idx]  <= load_bal;
`ifdef ATM_LOCKOUT_EN
            tfail[load_idx] <= '0;
`endif
          end
          if (start) begin
            req   <= '{card: card_in, pin: pin_in, op: op, amount: amount, new_pin: new_pin};
            idx   <= '0;
            state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (hit) begin
            state <= S_EXEC;
          end else if (idx == IW'(N)) begin
            status  <= ST_NOCARD;
            bal_out <= '0;
            state   <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_EXEC: begin
          status  <= ex_status;
          bal_out <= ex_bal;
          if (bal_we) tbal[idx] <= ex_bal;
          if (pin_we) tpin[idx] <= req.new_pin;
`ifdef ATM_LOCKOUT_EN
          if (ex_status == ST_BADPIN) begin
            if (tfail[idx] < FW'(MAX_TRIES)) tfail[idx] <= tfail[idx] + 1'b1;
          end else if (ex_status != ST_LOCKED) begin
            tfail[idx] <= '0;
          end
`endif
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
